// File: rtl/iq_sample_feeder.sv
// Collects little-endian byte quads from a show-ahead FIFO and emits one
// sign-extended, left-shifted I/Q pair per quad into the paired radio input FIFOs.
module iq_sample_feeder #(
    parameter int unsigned QUANT_BITS = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [31:0]           sample_count
);

    typedef enum logic [2:0] {
        S_B0,
        S_B1,
        S_B2,
        S_B3,
        S_WRITE
    } state_t;

    state_t                r_state;
    logic [7:0]            r_b0;
    logic [7:0]            r_b1;
    logic [7:0]            r_b2;
    logic [7:0]            r_b3;
    logic [31:0]           r_count;
    logic [DATA_WIDTH-1:0] w_i_ext;
    logic [DATA_WIDTH-1:0] w_q_ext;

    // Handshakes are gated by reset so nothing is popped or written while held.
    assign in_rd_en  = reset && !in_empty && (r_state != S_WRITE);
    assign out_wr_en = reset && !out_full && (r_state == S_WRITE);

    assign w_i_ext = {{(DATA_WIDTH-16){r_b1[7]}}, r_b1, r_b0};
    assign w_q_ext = {{(DATA_WIDTH-16){r_b3[7]}}, r_b3, r_b2};
    assign i_out   = w_i_ext << QUANT_BITS;
    assign q_out   = w_q_ext << QUANT_BITS;

    assign sample_count = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_B0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
            r_b3    <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_B0: if (!in_empty) begin
                    r_b0    <= in_dout;
                    r_state <= S_B1;
                end
                S_B1: if (!in_empty) begin
                    r_b1    <= in_dout;
                    r_state <= S_B2;
                end
                S_B2: if (!in_empty) begin
                    r_b2    <= in_dout;
                    r_state <= S_B3;
                end
                S_B3: if (!in_empty) begin
                    r_b3    <= in_dout;
                    r_state <= S_WRITE;
                end
                S_WRITE: if (!out_full) begin
                    r_count <= r_count + 32'd1;
                    r_state <= S_B0;
                end
                default: r_state <= S_B0;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_sample_feeder.sv
// Scoreboard bench for iq_sample_feeder: a byte-stream reference model queues
// expected I/Q pairs; an independent monitor checks every write against it.
module tb_iq_sample_feeder;

    localparam int unsigned QB = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] i_out;
    logic [31:0] q_out;
    logic        out_wr_en;
    logic        out_full;
    logic [31:0] sample_count;

    iq_sample_feeder #(.QUANT_BITS(QB), .DATA_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_dout      (in_dout),
        .in_empty     (in_empty),
        .in_rd_en     (in_rd_en),
        .i_out        (i_out),
        .q_out        (q_out),
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .sample_count (sample_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        int unsigned cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  src[$];
    logic [7:0]  part[$];
    int unsigned rd_cycles[$];
    int unsigned wr_cycles[$];
    int unsigned model_cnt = 0;
    int unsigned cyc = 0;
    int unsigned cnt_pend = 0;
    int          checks = 0;
    int          failures = 0;
    bit          gap = 1'b0;
    bit          rd_pend = 1'b0;
    bit          cnt_chk = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: signed 16-bit value times 2^QB, kept to the low 32 bits.
    function automatic logic [31:0] quant(input logic [7:0] lo, input logic [7:0] hi);
        longint v;
        v = longint'(hi) * 256 + longint'(lo);
        if (v >= 32768) v = v - 65536;
        for (int k = 0; k < int'(QB); k++) v = v * 2;
        return v[31:0];
    endfunction

    task automatic push_byte(input logic [7:0] b);
        src.push_back(b);
        part.push_back(b);
        if (part.size() == 4) begin
            exp_t e;
            e.i = quant(part[0], part[1]);
            e.q = quant(part[2], part[3]);
            model_cnt++;
            e.cnt = model_cnt;
            exp_q.push_back(e);
            part.delete();
        end
    endtask

    task automatic model_reset();
        part.delete();
        model_cnt = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || cnt_chk || src.size() > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_rd(input int unsigned want, input int budget, input string name);
        int n;
        n = 0;
        while (rd_cycles.size() < want && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_rd_timeout: got %0d pops required %0d", name, rd_cycles.size(), want);
        end
    endtask

    task automatic check_reset_state(input string name);
        check32({name, "_rd_en"}, 32'(in_rd_en), 32'd0);
        check32({name, "_wr_en"}, 32'(out_wr_en), 32'd0);
        check32({name, "_i_out"}, i_out, 32'd0);
        check32({name, "_q_out"}, q_out, 32'd0);
        check32({name, "_count"}, sample_count, 32'd0);
    endtask

    // Show-ahead source FIFO: pop on a sampled in_rd_en, present the new head.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (rd_pend && src.size() > 0) void'(src.pop_front());
        rd_pend  = 1'b0;
        in_empty = gap || (src.size() == 0);
        in_dout  = (src.size() > 0) ? src[0] : 8'h00;
    end

    always @(negedge clock) begin
        if (cnt_chk) begin
            check32("sample_count", sample_count, cnt_pend);
            cnt_chk = 1'b0;
        end
        rd_pend = in_rd_en;
        if (reset) begin
            if (in_rd_en) begin
                rd_cycles.push_back(cyc);
                check32("rd_while_empty", 32'(in_empty), 32'd0);
            end
            if (out_wr_en) begin
                wr_cycles.push_back(cyc);
                check32("wr_while_full", 32'(out_full), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got i=%h q=%h required no write", i_out, q_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32("i_out", i_out, e.i);
                    check32("q_out", q_out, e.q);
                    cnt_pend = e.cnt;
                    cnt_chk  = 1'b1;
                end
            end
        end
    end

    initial begin
        int unsigned c0;
        int groups;
        int n;
        reset    = 1'b1;
        in_dout  = 8'h00;
        in_empty = 1'b1;
        out_full = 1'b0;
        #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_state("por");
        step();
        reset = 1'b1;
        step();

        // Case 1: basic sample and pop-to-write latency.
        rd_cycles.delete();
        wr_cycles.delete();
        push_byte(8'h34); push_byte(8'h12); push_byte(8'hCE); push_byte(8'hFF);
        drain(50, "t1");
        check32("t1_pops", rd_cycles.size(), 32'd4);
        check32("t1_writes", wr_cycles.size(), 32'd1);
        if (rd_cycles.size() > 0 && wr_cycles.size() > 0)
            check32("t1_latency", wr_cycles[0] - rd_cycles[0], 32'd4);

        // Case 2: extreme magnitudes.
        push_byte(8'h00); push_byte(8'h80); push_byte(8'hFF); push_byte(8'h7F);
        drain(50, "t2");

        // Case 3: backpressure for 10 cycles with more bytes waiting.
        rd_cycles.delete();
        wr_cycles.delete();
        out_full = 1'b1;
        push_byte(8'h34); push_byte(8'h12); push_byte(8'hCE); push_byte(8'hFF);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        wait_rd(4, 50, "t3");
        c0 = (rd_cycles.size() >= 4) ? rd_cycles[3] : 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check32("t3_stall_wr", 32'(out_wr_en), 32'd0);
            check32("t3_stall_rd", 32'(in_rd_en), 32'd0);
            check32("t3_stall_i", i_out, 32'h0048D000);
            check32("t3_stall_q", q_out, 32'hFFFF3800);
        end
        step();
        out_full = 1'b0;
        drain(50, "t3");
        if (wr_cycles.size() > 0) check32("t3_release_cycle", wr_cycles[0], c0 + 11);
        check32("t3_pops", rd_cycles.size(), 32'd8);

        // Case 4: empty gaps between bytes.
        rd_cycles.delete();
        begin
            logic [7:0] t4b[4];
            t4b = '{8'h34, 8'h12, 8'hCE, 8'hFF};
            for (int k = 0; k < 4; k++) begin
                gap = 1'b1;
                push_byte(t4b[k]);
                repeat (3) step();
                gap = 1'b0;
                wait_rd(k + 1, 20, "t4");
            end
        end
        drain(50, "t4");
        check32("t4_pops", rd_cycles.size(), 32'd4);

        // Case 5: reset mid-group discards the partial sample.
        rd_cycles.delete();
        push_byte(8'hAA); push_byte(8'hBB);
        wait_rd(2, 20, "t5");
        step();
        reset = 1'b0;
        model_reset();
        push_byte(8'h01); push_byte(8'h00); push_byte(8'h02); push_byte(8'h00);
        step();
        @(negedge clock);
        check_reset_state("t5_rst");
        step();
        reset = 1'b1;
        drain(50, "t5");
        check32("t5_count", sample_count, 32'd1);

        // Case 6: 12 back-to-back bytes from a fresh reset.
        step();
        reset = 1'b0;
        model_reset();
        step();
        reset = 1'b1;
        rd_cycles.delete();
        wr_cycles.delete();
        for (int k = 0; k < 12; k++) push_byte(8'($urandom));
        drain(100, "t6");
        check32("t6_pops", rd_cycles.size(), 32'd12);
        check32("t6_writes", wr_cycles.size(), 32'd3);
        if (wr_cycles.size() == 3) begin
            check32("t6_gap1", wr_cycles[1] - wr_cycles[0], 32'd5);
            check32("t6_gap2", wr_cycles[2] - wr_cycles[1], 32'd5);
        end
        check32("t6_count", sample_count, 32'd3);

        // Random traffic with random empty gaps and backpressure.
        groups = 0;
        n = 0;
        while (groups < 40 && n < 5000) begin
            if (src.size() < 6) begin
                repeat (4) push_byte(8'($urandom));
                groups++;
            end
            gap      = ($urandom_range(0, 3) == 0);
            out_full = ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        gap      = 1'b0;
        out_full = 1'b0;
        drain(1000, "rand");
        check32("final_count", sample_count, model_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
